// File: rtl/adc_avg_bargraph.sv
// rtl/adc_avg_bargraph.sv - windowed ADC averager with hysteretic LED bargraph, min/max and stale detection
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   sample_valid          one-cycle strobe qualifying sample_data
//   sample_data[11:0]     unsigned raw ADC result
//   clear_minmax          restart min/max tracking
//   flush                 empty the averaging window (avg_out/led untouched)
//   avg_out[11:0]         mean of the last 2**LOG2_DEPTH samples
//   avg_valid             one-cycle pulse on each avg_out update
//   led[7:0]              thermometer bargraph of avg_out with hysteresis
//   min_out/max_out[11:0] extremes of raw accepted samples
//   stale                 no sample for TIMEOUT cycles
module adc_avg_bargraph #(
    parameter int LOG2_DEPTH = 3,
    parameter int HYST       = 32,
    parameter int TIMEOUT    = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] sample_data,
    input  logic        clear_minmax,
    input  logic        flush,
    output logic [11:0] avg_out,
    output logic        avg_valid,
    output logic [7:0]  led,
    output logic [11:0] min_out,
    output logic [11:0] max_out,
    output logic        stale
);

    localparam int DEPTH  = 1 << LOG2_DEPTH;
    localparam int SUM_W  = 12 + LOG2_DEPTH;
    localparam int FILL_W = LOG2_DEPTH + 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [11:0]           win_q [DEPTH];
    logic [11:0]           win_d [DEPTH];
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [LOG2_DEPTH-1:0] ptr_q, ptr_d;
    logic [11:0]           avg_q, avg_d;
    logic                  avg_valid_q, avg_valid_d;
    logic [7:0]            led_q, led_d;
    logic [11:0]           min_q, min_d;
    logic [11:0]           max_q, max_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;

    // Window state as seen by an incoming sample: a coincident flush means
    // the sample lands in an already-empty window.
    logic [SUM_W-1:0]      base_sum;
    logic [FILL_W-1:0]     base_fill;
    logic [LOG2_DEPTH-1:0] base_ptr;
    logic [11:0]           old_entry;

    always_comb begin
        base_sum  = flush ? '0 : sum_q;
        base_fill = flush ? '0 : fill_q;
        base_ptr  = flush ? '0 : ptr_q;
        old_entry = flush ? '0 : win_q[ptr_q];

        win_d       = win_q;
        sum_d       = base_sum;
        fill_d      = base_fill;
        ptr_d       = base_ptr;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        led_d       = led_q;
        min_d       = min_q;
        max_d       = max_q;
        idle_d      = idle_q;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_d[i] = '0;
            end
        end

        if (sample_valid) begin
            win_d[base_ptr] = sample_data;
            // Unfilled slots hold 0, so subtracting the overwritten entry
            // keeps the sum equal to the window contents; it cannot overflow.
            sum_d  = base_sum + SUM_W'(sample_data) - SUM_W'(old_entry);
            ptr_d  = base_ptr + LOG2_DEPTH'(1);
            fill_d = (base_fill == FILL_W'(DEPTH)) ? base_fill : base_fill + FILL_W'(1);
            if (fill_d == FILL_W'(DEPTH)) begin
                avg_d       = sum_d[SUM_W-1:LOG2_DEPTH];
                avg_valid_d = 1'b1;
            end
        end

        if (clear_minmax) begin
            min_d = sample_valid ? sample_data : 12'hFFF;
            max_d = sample_valid ? sample_data : 12'h000;
        end else if (sample_valid) begin
            if (sample_data < min_q) min_d = sample_data;
            if (sample_data > max_q) max_d = sample_data;
        end

        if (sample_valid) begin
            idle_d = '0;
        end else if (idle_q != IDLE_W'(TIMEOUT)) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        // Bargraph re-evaluates once per avg_out update, one cycle behind it.
        // Between the two thresholds each bit keeps its previous state.
        if (avg_valid_q) begin
            for (int i = 0; i < 8; i++) begin
                if (int'(avg_q) >= 512 * i + 256 + HYST) begin
                    led_d[i] = 1'b1;
                end else if (int'(avg_q) < 512 * i + 256 - HYST) begin
                    led_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            sum_q       <= '0;
            fill_q      <= '0;
            ptr_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            led_q       <= '0;
            min_q       <= 12'hFFF;
            max_q       <= 12'h000;
            idle_q      <= '0;
        end else begin
            win_q       <= win_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            ptr_q       <= ptr_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            led_q       <= led_d;
            min_q       <= min_d;
            max_q       <= max_d;
            idle_q      <= idle_d;
        end
    end

    assign avg_out   = avg_q;
    assign avg_valid = avg_valid_q;
    assign led       = led_q;
    assign min_out   = min_q;
    assign max_out   = max_q;
    assign stale     = (idle_q == IDLE_W'(TIMEOUT));

endmodule

// File: tb/tb_adc_avg_bargraph.sv
// tb/tb_adc_avg_bargraph.sv - directed self-checking bench for adc_avg_bargraph
module tb_adc_avg_bargraph;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic        clear_minmax;
    logic        flush;
    logic [11:0] avg_out;
    logic        avg_valid;
    logic [7:0]  led;
    logic [11:0] min_out;
    logic [11:0] max_out;
    logic        stale;

    int checks = 0;
    int errors = 0;

    adc_avg_bargraph #(
        .LOG2_DEPTH(3),
        .HYST      (32),
        .TIMEOUT   (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .clear_minmax(clear_minmax),
        .flush       (flush),
        .avg_out     (avg_out),
        .avg_valid   (avg_valid),
        .led         (led),
        .min_out     (min_out),
        .max_out     (max_out),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Idle cycle; sample_data is scrambled to show it is ignored without the strobe.
    task automatic tick();
        sample_data = 12'($urandom);
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [11:0] v);
        sample_valid = 1'b1;
        sample_data  = v;
        @(negedge clk);
        sample_valid = 1'b0;
        flush        = 1'b0;
        clear_minmax = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        clear_minmax = 1'b0;
        flush        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_avg", 32'(avg_out), 32'h000);
        chk("rst_valid", 32'(avg_valid), 32'h0);
        chk("rst_led", 32'(led), 32'h00);
        chk("rst_min", 32'(min_out), 32'hFFF);
        chk("rst_max", 32'(max_out), 32'h000);
        chk("rst_stale", 32'(stale), 32'h0);
        reset = 1'b0;

        // Scenario 1: eight samples of 0x800
        for (int i = 0; i < 7; i++) send(12'h800);
        chk("s1_no_valid_at_7", 32'(avg_valid), 32'h0);
        send(12'h800);
        chk("s1_valid_at_8", 32'(avg_valid), 32'h1);
        chk("s1_avg", 32'(avg_out), 32'h800);
        tick();
        chk("s1_valid_single", 32'(avg_valid), 32'h0);
        chk("s1_led", 32'(led), 32'h0F);

        // Scenario 2: one 0xFFF -> sum 18431 -> 2303
        send(12'hFFF);
        chk("s2_valid", 32'(avg_valid), 32'h1);
        chk("s2_avg", 32'(avg_out), 32'h8FF);
        tick();
        chk("s2_led", 32'(led), 32'h0F);
        chk("s2_max", 32'(max_out), 32'hFFF);
        chk("s2_min", 32'(min_out), 32'h800);

        // Scenario 3: min/max tracking and clear
        clear_minmax = 1'b1;
        tick();
        clear_minmax = 1'b0;
        chk("s3_clr_min", 32'(min_out), 32'hFFF);
        chk("s3_clr_max", 32'(max_out), 32'h000);
        send(12'h123);
        send(12'hABC);
        send(12'h050);
        chk("s3_min", 32'(min_out), 32'h050);
        chk("s3_max", 32'(max_out), 32'hABC);
        clear_minmax = 1'b1;
        send(12'h400);
        chk("s3_clr_samp_min", 32'(min_out), 32'h400);
        chk("s3_clr_samp_max", 32'(max_out), 32'h400);
        // window 800,800,800,FFF,123,ABC,050,400 = 14382 -> 1797
        chk("s3_avg", 32'(avg_out), 32'h705);
        tick();
        // 1797 sits inside led[3]'s band (1760..1823) so the bit holds
        chk("s3_led_hold", 32'(led), 32'h0F);

        // flush alone leaves avg_out and led untouched
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_avg_kept", 32'(avg_out), 32'h705);
        chk("flush_led_kept", 32'(led), 32'h0F);

        // Scenario 4: hysteresis on led[4]; flush+clear+sample start a new window
        flush        = 1'b1;
        clear_minmax = 1'b1;
        send(12'd2336);
        chk("s4_comb_min", 32'(min_out), 32'd2336);
        chk("s4_comb_max", 32'(max_out), 32'd2336);
        chk("s4_comb_novalid", 32'(avg_valid), 32'h0);
        for (int i = 0; i < 6; i++) send(12'd2336);
        chk("s4_no_valid_at_7", 32'(avg_valid), 32'h0);
        send(12'd2336);
        chk("s4_valid_at_8", 32'(avg_valid), 32'h1);
        chk("s4_avg_2336", 32'(avg_out), 32'd2336);
        tick();
        chk("s4_led_on", 32'(led), 32'h1F);
        for (int i = 0; i < 8; i++) send(12'd2290);
        chk("s4_avg_2290", 32'(avg_out), 32'd2290);
        tick();
        chk("s4_led_hold", 32'(led), 32'h1F);
        for (int i = 0; i < 8; i++) send(12'd2271);
        chk("s4_avg_2271", 32'(avg_out), 32'd2271);
        tick();
        chk("s4_led_off", 32'(led), 32'h0F);

        // Scenario 5: stale after exactly 100 idle cycles
        send(12'h321);
        for (int i = 0; i < 99; i++) tick();
        chk("s5_not_stale_99", 32'(stale), 32'h0);
        tick();
        chk("s5_stale_100", 32'(stale), 32'h1);
        tick();
        chk("s5_stale_sat", 32'(stale), 32'h1);
        send(12'h321);
        chk("s5_stale_clear", 32'(stale), 32'h0);

        // Scenario 6: reset mid-window; only post-reset samples count
        for (int i = 0; i < 5; i++) send(12'hFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s6_rst_avg", 32'(avg_out), 32'h000);
        chk("s6_rst_led", 32'(led), 32'h00);
        chk("s6_rst_min", 32'(min_out), 32'hFFF);
        for (int i = 1; i <= 7; i++) send(12'(16 * i));
        chk("s6_no_valid_at_7", 32'(avg_valid), 32'h0);
        send(12'd128);
        chk("s6_valid_at_8", 32'(avg_valid), 32'h1);
        // (16+32+...+112+128)/8 = 576/8 = 72
        chk("s6_avg", 32'(avg_out), 32'd72);
        chk("s6_min", 32'(min_out), 32'd16);
        chk("s6_max", 32'(max_out), 32'd128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
